mem_wb_stage: RTL and testbench

//  Back end of the 32-bit MIPS pipeline: accepts EX-stage results and performs data-memory load/store.

---
 rtl/mem_wb_stage.sv | 151 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB back end: data memory, load-wait FSM, write-back port, retire counter.
// Optional WB->EX forwarding tap is built only when MEM_WB_FORWARD_EN is defined.
module mem_wb_stage #(
  parameter int DMEM_AW = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       ex_op,
  input  logic [31:0]      ex_alu_result,
  input  logic [31:0]      ex_store_data,
  input  logic [4:0]       ex_dest,
  input  logic             ex_reg_write,
  output logic             mem_stall,
  output logic             write,
  output logic [4:0]       write_address,
  output logic [31:0]      write_material,
  output logic [CNT_W-1:0] retired,
  output logic             fwd_valid,
  output logic [4:0]       fwd_addr,
  output logic [31:0]      fwd_data
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  localparam logic [1:0]       OP_ALU   = 2'b00;
  localparam logic [1:0]       OP_LOAD  = 2'b01;
  localparam logic [1:0]       OP_STORE = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               mem_stall_q, mem_stall_d;
  logic               write_q, write_d;
  logic [4:0]         waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [4:0]         ld_dest_q, ld_dest_d;
  logic               ld_we_q, ld_we_d;
  logic [31:0]        rd_data_q;

  logic [31:0]        mem [0:(1<<DMEM_AW)-1];

  logic               accept;
  logic               wb_en;
  logic               mem_we;
  logic               mem_re;
  logic [DMEM_AW-1:0] idx;

  // Word index: byte-offset bits dropped, upper address bits wrap.
  assign idx    = ex_alu_result[DMEM_AW+1:2];
  assign accept = ex_valid & ~mem_stall_q & (state_q == IDLE);
  assign wb_en  = ex_reg_write & (ex_dest != 5'd0);

  always_comb begin
    state_d     = state_q;
    mem_stall_d = 1'b0;
    write_d     = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    retired_d   = retired_q;
    ld_dest_d   = ld_dest_q;
    ld_we_d     = ld_we_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (ex_op)
            OP_ALU: begin
              write_d   = wb_en;
              retired_d = retired_q + CNT_ONE;
              if (wb_en) begin
                waddr_d = ex_dest;
                wdata_d = ex_alu_result;
              end
            end
            OP_LOAD: begin
              state_d     = LOAD_WAIT;
              mem_stall_d = 1'b1;
              mem_re      = 1'b1;
              ld_dest_d   = ex_dest;
              ld_we_d     = wb_en;
            end
            OP_STORE: begin
              mem_we    = 1'b1;
              retired_d = retired_q + CNT_ONE;
            end
            default: ;
          endcase
        end
      end
      LOAD_WAIT: begin
        // Read data captured at accept is now stable; retire the load.
        state_d   = IDLE;
        write_d   = ld_we_q;
        retired_d = retired_q + CNT_ONE;
        if (ld_we_q) begin
          waddr_d = ld_dest_q;
          wdata_d = rd_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_stall_q <= 1'b0;
      write_q     <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'd0;
      retired_q   <= '0;
      ld_dest_q   <= 5'd0;
      ld_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_stall_q <= mem_stall_d;
      write_q     <= write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      retired_q   <= retired_d;
      ld_dest_q   <= ld_dest_d;
      ld_we_q     <= ld_we_d;
    end
  end

  // Data memory is never cleared; reads are synchronous.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx] <= ex_store_data;
    if (mem_re) rd_data_q <= mem[idx];
  end

  assign mem_stall      = mem_stall_q;
  assign write          = write_q;
  assign write_address  = waddr_q;
  assign write_material = wdata_q;
  assign retired        = retired_q;

`ifdef MEM_WB_FORWARD_EN
  assign fwd_valid = write_q & (state_q != LOAD_WAIT);
  assign fwd_addr  = waddr_q;
  assign fwd_data  = wdata_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage (vector table + write-back scoreboard).
module tb_mem_wb_stage;

  localparam int DMEM_AW = 8;
  localparam int CNT_W   = 4;

  localparam logic [1:0] ALU = 2'b00, LOAD = 2'b01, STORE = 2'b10, NOP = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic [1:0]       ex_op;
  logic [31:0]      ex_alu_result;
  logic [31:0]      ex_store_data;
  logic [4:0]       ex_dest;
  logic             ex_reg_write;
  logic             mem_stall;
  logic             write;
  logic [4:0]       write_address;
  logic [31:0]      write_material;
  logic [CNT_W-1:0] retired;
  logic             fwd_valid;
  logic [4:0]       fwd_addr;
  logic [31:0]      fwd_data;

  mem_wb_stage #(.DMEM_AW(DMEM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .mem_stall(mem_stall),
    .write(write), .write_address(write_address), .write_material(write_material),
    .retired(retired), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        ew;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        tbl[13];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_ret = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ret_mod(input int r);
    return 32'(r % (1 << CNT_W));
  endfunction

  // Write-back monitor: every write pulse must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    if (mon_en) begin
      if (write === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(write_address), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(e.due));
          chk("wb_addr", 32'(write_address), 32'(e.addr));
          chk("wb_data", write_material, e.data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("missed_write", 32'(write), 32'd1);
      end
`ifdef MEM_WB_FORWARD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(write === 1'b1 && !mem_stall));
      if (write === 1'b1) begin
        chk("fwd_addr", 32'(fwd_addr), 32'(e.addr));
        chk("fwd_data", fwd_data, e.data);
      end
`else
      chk("fwd_tied", {31'(fwd_addr) | fwd_data} | 32'(fwd_valid), 32'd0);
`endif
    end
  end

  task automatic issue(input vec_t v);
    int bound = 0;
    ex_valid = 1'b1; ex_op = v.op; ex_alu_result = v.a;
    ex_store_data = v.sd; ex_dest = v.dest; ex_reg_write = v.rw;
    while (mem_stall && bound < 8) begin
      @(posedge clk); #1;
      bound++;
    end
    if (bound >= 8) chk("accept_timeout", 32'(mem_stall), 32'd0);
    if (v.ew && v.op == ALU)  sb.push_back('{cyc + 1, v.dest, v.ed});
    if (v.ew && v.op == LOAD) sb.push_back('{cyc + 2, v.dest, v.ed});
    if (v.ew) begin last_addr = v.dest; last_data = v.ed; end
    @(posedge clk); #1;
    case (v.op)
      LOAD: begin
        chk("stall_after_load", 32'(mem_stall), 32'd1);
        chk("retired_load_pending", 32'(retired), ret_mod(exp_ret));
        exp_ret++;
      end
      NOP: begin
        chk("stall_after_nop", 32'(mem_stall), 32'd0);
        chk("retired_nop", 32'(retired), ret_mod(exp_ret));
      end
      default: begin
        exp_ret++;
        chk("stall_after_op", 32'(mem_stall), 32'd0);
        chk("retired_op", 32'(retired), ret_mod(exp_ret));
      end
    endcase
    ex_valid = 1'b0; ex_op = NOP;
  endtask

  task automatic drain_and_check(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_retired"}, 32'(retired), ret_mod(exp_ret));
    chk({tag, "_write_idle"}, 32'(write), 32'd0);
    chk({tag, "_hold_addr"}, 32'(write_address), 32'(last_addr));
    chk({tag, "_hold_data"}, write_material, last_data);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{ALU,   32'hDEADBEEF, 32'h0,        5'd5,  1'b1, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{STORE, 32'h0000_0010, 32'h12345678, 5'd0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{LOAD,  32'h0000_0010, 32'h0,        5'd7,  1'b1, 1'b1, 32'h12345678};
    tbl[3]  = '{ALU,   32'h0000_0001, 32'h0,        5'd0,  1'b1, 1'b0, 32'h0};
    tbl[4]  = '{STORE, 32'h0000_0404, 32'h000000A5, 5'd0,  1'b0, 1'b0, 32'h0};
    tbl[5]  = '{LOAD,  32'h0000_0004, 32'h0,        5'd9,  1'b1, 1'b1, 32'h000000A5};
    tbl[6]  = '{NOP,   32'h0000_0010, 32'h0,        5'd1,  1'b1, 1'b0, 32'h0};
    tbl[7]  = '{LOAD,  32'h0000_0010, 32'h0,        5'd3,  1'b1, 1'b1, 32'h12345678};
    tbl[8]  = '{LOAD,  32'h0000_0407, 32'h0,        5'd4,  1'b1, 1'b1, 32'h000000A5};
    tbl[9]  = '{ALU,   32'hCAFEF00D, 32'h0,        5'd31, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{ALU,   32'h0001_2345, 32'h0,        5'd31, 1'b1, 1'b1, 32'h0001_2345};
    tbl[11] = '{STORE, 32'h0000_03FC, 32'hFFFF0000, 5'd0,  1'b0, 1'b0, 32'h0};
    tbl[12] = '{LOAD,  32'hFFFF_FFFC, 32'h0,        5'd2,  1'b1, 1'b1, 32'hFFFF0000};

    rst = 1'b1; ex_valid = 1'b0; ex_op = NOP; ex_alu_result = 32'h0;
    ex_store_data = 32'h0; ex_dest = 5'd0; ex_reg_write = 1'b0;
    last_addr = 5'd0; last_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_addr", 32'(write_address), 32'd0);
    chk("rst_data", write_material, 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_fwd", {31'(fwd_addr) | fwd_data} | 32'(fwd_valid), 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) issue(tbl[i]);
    drain_and_check("table");

    // Reset while a load is waiting must abort it with no write-back.
    ex_valid = 1'b1; ex_op = LOAD; ex_alu_result = 32'h10; ex_dest = 5'd8; ex_reg_write = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = NOP;
    chk("abort_stall_set", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0; last_addr = 5'd0; last_data = 32'h0;
    chk("abort_stall_clr", 32'(mem_stall), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    chk("abort_write", 32'(write), 32'd0);
    drain_and_check("abort");

    // Memory survives reset; then enough ALU ops to wrap the 4-bit counter.
    v = '{LOAD, 32'h0000_0010, 32'h0, 5'd6, 1'b1, 1'b1, 32'h12345678};
    issue(v);
    for (int i = 0; i < 18; i++) begin
      v.op = ALU; v.a = $urandom; v.sd = 32'h0; v.dest = 5'($urandom_range(1, 31));
      v.rw = 1'b1; v.ew = 1'b1; v.ed = v.a;
      issue(v);
    end
    drain_and_check("wrap");
    chk("wrap_value", 32'(retired), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
